// File: rtl/sraml_bus_if.sv
// Sram-like bus between a CPU-side bridge (master) and a memory responder (slave).
// Handshake is req & addr_ok. data_ok is a one-cycle completion pulse.
interface sraml_bus_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sraml_mem_responder.sv
// Sram-like slave memory model: one outstanding transaction, fixed-latency data_ok,
// word-organised storage with byte-lane writes and full-word reads.
module sraml_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  sraml_bus_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              addr_ok_q, addr_ok_nxt;
  logic              data_ok_q, data_ok_nxt;
  logic [31:0]       rdata_q;
  req_t              txn;
  logic              hs;
  logic              rd_wr;
  logic [ADDR_W-1:0] rd_idx, txn_idx;
  logic [3:0]        wstrb;
  logic              unused_hi;
  logic [31:0]       mem [DEPTH];

  assign bus.addr_ok = addr_ok_q;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

  // Upper address bits alias modulo DEPTH*4.
  assign unused_hi = ^bus.addr[31:ADDR_W+2];

  assign hs      = bus.req & addr_ok_q;
  assign txn_idx = txn.addr[ADDR_W+1:2];
  // With LATENCY=1 the read is served on the handshake edge, before txn is loaded.
  assign rd_idx  = hs ? bus.addr[ADDR_W+1:2] : txn_idx;
  assign rd_wr   = hs ? bus.wr : txn.wr;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_ok_nxt = addr_ok_q;
    data_ok_nxt = 1'b0;
    case (state)
      IDLE: begin
        addr_ok_nxt = 1'b1;
        if (hs) begin
          addr_ok_nxt = 1'b0;
          cnt_nxt     = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt   = RESP;
            data_ok_nxt = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt   = RESP;
          data_ok_nxt = 1'b1;
        end
      end
      RESP: begin
        state_nxt   = IDLE;
        addr_ok_nxt = 1'b1;
      end
      default: begin
        state_nxt   = IDLE;
        addr_ok_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      txn       <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr_ok_q <= addr_ok_nxt;
      data_ok_q <= data_ok_nxt;
      if (hs)
        txn <= '{wr: bus.wr, size: bus.size, addr: bus.addr[ADDR_W+1:0], wdata: bus.wdata};
      if (data_ok_nxt && !rd_wr)
        rdata_q <= mem[rd_idx];
    end
  end

  // Misaligned half/word writes get an empty strobe but still complete.
  always_comb begin
    case (txn.size)
      2'd0:    wstrb = 4'b0001 << txn.addr[1:0];
      2'd1:    wstrb = txn.addr[0] ? 4'b0000 : (4'b0011 << txn.addr[1:0]);
      default: wstrb = (txn.addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
    endcase
  end

  // Commit on the edge that closes RESP, so a reset anywhere earlier drops the write.
  always_ff @(posedge clk) begin
    if (state == RESP && txn.wr) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[txn_idx][8*b +: 8] <= txn.wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_sraml_mem_responder.sv
// Directed bench for sraml_mem_responder: vector table of transactions plus
// hand-written reset, back-pressure and mid-transaction reset sequences.
module tb_sraml_mem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sraml_bus_if bus ();

  sraml_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  int          ovl    = 0;
  logic [31:0] last_rd = '0;

  always @(negedge clk) if (bus.data_ok && bus.addr_ok) ovl++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic do_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output bit ok);
    int t;
    ok = 0; lat = 0; rd = '0;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.addr = a; bus.wdata = wd;
    t = 0;
    while (!bus.addr_ok && t < 50) begin @(negedge clk); t++; end
    if (!bus.addr_ok) begin bus.req = 1'b0; return; end
    @(posedge clk); #1 bus.req = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.data_ok && lat < 50) begin @(negedge clk); lat++; end
    if (!bus.data_ok) return;
    rd = bus.rdata;
    ok = 1;
    @(negedge clk);
    chk("pulse_end", {30'd0, bus.data_ok, bus.addr_ok}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, n_hs, n_dok, cyc, dok;
    int          hs_at[3];
    bit          ok, rd_good;

    vt.push_back('{1'b1, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF});
    vt.push_back('{1'b1, 2'd2, 32'h20,   32'h00000000, 32'h0});
    vt.push_back('{1'b1, 2'd0, 32'h23,   32'hAB000000, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h20,   32'h0,        32'hAB000000});
    vt.push_back('{1'b1, 2'd1, 32'h20,   32'h00001234, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h20,   32'h0,        32'hAB001234});
    vt.push_back('{1'b1, 2'd2, 32'h30,   32'h5A5A5A5A, 32'h0});
    vt.push_back('{1'b1, 2'd1, 32'h31,   32'hFFFFFFFF, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h30,   32'h0,        32'h5A5A5A5A});
    vt.push_back('{1'b1, 2'd1, 32'h32,   32'hBEEF0000, 32'h0});
    vt.push_back('{1'b0, 2'd0, 32'h31,   32'h0,        32'hBEEF5A5A});
    vt.push_back('{1'b1, 2'd3, 32'h50,   32'h01234567, 32'h0});
    vt.push_back('{1'b1, 2'd0, 32'h51,   32'h0000EE00, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h50,   32'h0,        32'h0123EE67});
    vt.push_back('{1'b1, 2'd2, 32'h54,   32'h0BADF00D, 32'h0});
    vt.push_back('{1'b1, 2'd2, 32'h56,   32'hFFFFFFFF, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h54,   32'h0,        32'h0BADF00D});
    vt.push_back('{1'b1, 2'd2, 32'h1000, 32'hCAFEF00D, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h0,    32'h0,        32'hCAFEF00D});
    vt.push_back('{1'b1, 2'd2, 32'h40,   32'h11111111, 32'h0});

    // Reset held with req asserted.
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr_ok", {31'd0, bus.addr_ok}, 32'd0);
    chk("rst_data_ok", {31'd0, bus.data_ok}, 32'd0);
    chk("rst_rdata",   bus.rdata,            32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_addr_ok", {31'd0, bus.addr_ok}, 32'd1);
    chk("rel_data_ok", {31'd0, bus.data_ok}, 32'd0);
    bus.req = 1'b0;

    foreach (vt[i]) begin
      do_txn(vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, rd, lat, ok);
      chk($sformatf("v%0d_done", i), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d_lat", i), lat, LAT);
      if (!vt[i].wr) begin
        chk($sformatf("v%0d_rdata", i), rd, vt[i].exp);
        last_rd = vt[i].exp;
      end else begin
        chk($sformatf("v%0d_rdata_hold", i), rd, last_rd);
      end
    end

    // Back-pressure: req held for three reads.
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h10;
    n_hs = 0; n_dok = 0; rd_good = 1;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.data_ok) begin
        n_dok++;
        if (bus.rdata !== 32'hDEADBEEF) rd_good = 0;
      end
      if (bus.req && bus.addr_ok) begin
        if (n_hs < 3) hs_at[n_hs] = cyc;
        n_hs++;
        if (n_hs == 3) begin @(posedge clk); #1 bus.req = 1'b0; end
      end
    end
    chk("bp_handshakes", n_hs, 3);
    chk("bp_data_ok",    n_dok, 3);
    chk("bp_space0",     hs_at[1] - hs_at[0], LAT + 1);
    chk("bp_space1",     hs_at[2] - hs_at[1], LAT + 1);
    chk("bp_rdata",      {31'd0, rd_good}, 32'd1);
    last_rd = 32'hDEADBEEF;

    // Reset during WAIT of a write to 0x40.
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'd2; bus.addr = 32'h40; bus.wdata = 32'h22222222;
    cyc = 0;
    while (!bus.addr_ok && cyc < 50) begin @(negedge clk); cyc++; end
    chk("mid_hs_ready", {31'd0, bus.addr_ok}, 32'd1);
    @(posedge clk); #1 bus.req = 1'b0; resetn = 1'b0;
    dok = 0;
    repeat (3) begin @(negedge clk); if (bus.data_ok) dok++; end
    chk("mid_rst_rdata", bus.rdata, 32'd0);
    resetn = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.data_ok) dok++; end
    chk("mid_no_data_ok", dok, 0);
    do_txn(1'b0, 2'd2, 32'h40, 32'h0, rd, lat, ok);
    chk("mid_done", {31'd0, ok}, 32'd1);
    chk("mid_old_word", rd, 32'h11111111);

    chk("no_overlap", ovl, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
